// File: rtl/mdu_e.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_e
//  Description : E-stage multiply/divide unit with private HI/LO, fixed-latency
//                MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO support.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  md_op,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int C_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CW   = $clog2(C_MAXC + 1);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MFHI  = 4'd5;
  localparam logic [3:0] C_OP_MFLO  = 4'd6;
  localparam logic [3:0] C_OP_MTHI  = 4'd7;
  localparam logic [3:0] C_OP_MTLO  = 4'd8;

  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic        [31:0] w_divisor;
  logic signed [31:0] w_sq, w_sr;
  logic        [31:0] w_uq, w_ur;
  logic               w_ovf;

  assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_umul = {32'd0, A} * {32'd0, B};

  // The divisor is forced to 1 on B=0 so the divider never produces X; the
  // result is discarded in that case anyway.
  assign w_divisor = (B == 32'd0) ? 32'd1 : B;
  assign w_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    w_sq = $signed(A) / $signed(w_divisor);
    w_sr = $signed(A) % $signed(w_divisor);
    if (w_ovf) begin
      w_sq = 32'sh8000_0000;
      w_sr = 32'sd0;
    end
  end

  assign w_uq = A / w_divisor;
  assign w_ur = A % w_divisor;

  always_comb begin
    start = 1'b0;
    if (!busy_q) begin
      case (md_op)
        C_OP_MULT, C_OP_MULTU, C_OP_DIV, C_OP_DIVU: start = 1'b1;
        default:                                    start = 1'b0;
      endcase
    end
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q - C_CW'(1);
      if (cnt_q == C_CW'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else begin
      case (md_op)
        C_OP_MULT: begin
          {pend_hi_d, pend_lo_d} = w_smul;
          cnt_d  = C_CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        C_OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = w_umul;
          cnt_d  = C_CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        C_OP_DIV, C_OP_DIVU: begin
          // Divide by zero replays the current HI/LO so the commit is a no-op.
          if (B == 32'd0) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
          end else if (md_op == C_OP_DIV) begin
            pend_hi_d = w_sr;
            pend_lo_d = w_sq;
          end else begin
            pend_hi_d = w_ur;
            pend_lo_d = w_uq;
          end
          cnt_d  = C_CW'(DIV_CYCLES);
          busy_d = 1'b1;
        end
        C_OP_MTHI: hi_d = A;
        C_OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign md_out = (md_op == C_OP_MFHI) ? hi_q :
                  (md_op == C_OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_e.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_e
//  Description : Directed self-checking bench for mdu_e with a HI/LO scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  md_op;
  logic        start, busy;
  logic [31:0] HI, LO, md_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .md_op(md_op),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a mult/div in idle, expect start, push the expected {HI,LO}.
  task automatic start_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    md_op = op; A = a; B = b;
    #1;
    check({tag, ".start"}, 64'(start), 64'd1);
    sb.push_back(exp);
    step();
    md_op = 4'd0;
    #1;
    check({tag, ".busy_rise"}, 64'(busy), 64'd1);
  endtask

  // Count the remaining busy cycles, then pop and compare the committed result.
  task automatic wait_commit(input string tag, input int remaining);
    int n;
    logic [63:0] e;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      step();
    end
    check({tag, ".busy_cycles"}, 64'(n), 64'(remaining));
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".HI"}, 64'(HI), 64'(e[63:32]));
      check({tag, ".LO"}, 64'(LO), 64'(e[31:0]));
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    md_op = op; A = a; B = 32'd0;
    step();
    md_op = 4'd0;
    #1;
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; md_op = 4'd0;
    #23;
    reset = 1'b0;
    step();

    check("rst.HI",   64'(HI),   64'd0);
    check("rst.LO",   64'(LO),   64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    md_op = 4'd5; #1;
    check("rst.mfhi", 64'(md_out), 64'd0);
    md_op = 4'd9; #1;
    check("op9.start",  64'(start),  64'd0);
    check("op9.md_out", 64'(md_out), 64'd0);
    md_op = 4'd0; #1;

    // Signed and unsigned multiply of the same operands
    start_op("mult", 4'd1, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_commit("mult", 5);
    start_op("multu", 4'd2, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE);
    wait_commit("multu", 5);

    // -7/2 -> q=-3, r=-1 ; 7/2 -> q=3, r=1
    start_op("div", 4'd3, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_commit("div", 10);
    start_op("divu", 4'd4, 32'h7, 32'h2, 64'h0000_0001_0000_0003);
    wait_commit("divu", 10);

    // MTHI/MTLO and divide by zero leaving HI/LO untouched
    mt(4'd7, 32'h1234);
    md_op = 4'd5; #1;
    check("mthi.mfhi", 64'(md_out), 64'h1234);
    md_op = 4'd0;
    mt(4'd8, 32'h5678);
    check("mtlo.LO", 64'(LO), 64'h5678);
    start_op("div0", 4'd3, 32'h99, 32'h0, 64'h0000_1234_0000_5678);
    wait_commit("div0", 10);
    md_op = 4'd5; #1;
    check("mfhi", 64'(md_out), 64'h1234);
    md_op = 4'd6; #1;
    check("mflo", 64'(md_out), 64'h5678);
    md_op = 4'd0; #1;

    // Protocol violations while busy must be ignored
    start_op("intf", 4'd1, 32'h3, 32'h5, 64'h0000_0000_0000_000F);
    md_op = 4'd8; A = 32'hDEAD; #1;
    check("intf.mtlo_start", 64'(start), 64'd0);
    step();
    check("intf.LO_hold", 64'(LO), 64'h5678);
    md_op = 4'd4; A = 32'h7; B = 32'h2; #1;
    check("intf.divu_start", 64'(start), 64'd0);
    step();
    md_op = 4'd0; #1;
    check("intf.HI_hold", 64'(HI), 64'h1234);
    wait_commit("intf", 3);

    // Asynchronous reset in busy cycle 4 discards the pending result
    start_op("rstdiv", 4'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.HI",   64'(HI),   64'd0);
    check("arst.LO",   64'(LO),   64'd0);
    sb.delete();
    #2;
    reset = 1'b0;
    step();
    for (int i = 0; i < 12; i++) step();
    check("arst.post_busy", 64'(busy), 64'd0);
    check("arst.post_HI",   64'(HI),   64'd0);
    check("arst.post_LO",   64'(LO),   64'd0);

    // Signed overflow division, then a multiply accepted at the first idle edge
    start_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    wait_commit("divovf", 10);
    start_op("mult2", 4'd1, 32'h8000_0000, 32'h2, 64'hFFFF_FFFF_0000_0000);
    wait_commit("mult2", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_e.md
# mdu_e

Multiply/divide unit for the E stage of the five-stage pipeline. Takes the forwarded operands that feed the ALU (E-stage A and B after forwarding) and executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency into private HI/LO registers. Also serves MFHI/MFLO reads into the E→M result path and MTHI/MTLO writes. Exports `start` and `busy` so the hazard unit can stall the D stage on any multiply/divide-class instruction.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- A  in  32  forwarded rs value (E stage)
- B  in  32  forwarded rt value (E stage)
- md_op  in  4  decoded op of instr_E: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as none
- start  out  1  combinational: md_op ∈ {1..4} and !busy
- busy  out  1  registered: a multiply/divide is in flight
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- md_out  out  32  combinational: HI if md_op=5, LO if md_op=6, else 0

## Operation
- State: HI, LO, pend_hi, pend_lo (32 b each), cnt (4 b, wide enough for max(MULT_CYCLES, DIV_CYCLES)), busy.
- Idle (busy=0): on a clock edge with start=1:
  - MULT: {pend_hi, pend_lo} ← signed A×B, full 64 b.
  - MULTU: {pend_hi, pend_lo} ← unsigned A×B, full 64 b.
  - DIV: pend_lo ← signed A/B, truncated toward zero; pend_hi ← signed remainder, same sign as A.
  - DIVU: unsigned quotient/remainder.
  - cnt ← MULT_CYCLES or DIV_CYCLES; busy ← 1.
- Divide by zero (B=0, DIV or DIVU):
  - Busy sequence runs normally.
  - pend_hi/pend_lo ← current HI/LO, so HI/LO are unchanged at commit.
- Signed DIV 0x80000000 / 0xFFFFFFFF: LO ← 0x80000000, HI ← 0 (wrap, no trap).
- Busy (busy=1): each edge cnt ← cnt−1. On the edge where cnt=1: HI ← pend_hi, LO ← pend_lo, busy ← 0, cnt ← 0.
- MTHI/MTLO (md_op 7/8) with busy=0: HI or LO ← A on the edge.
- Ops 1–4 and 7–8 with busy=1 are ignored. The hazard unit guarantees these never reach E while busy; the block must still not corrupt state if they do.
- MFHI/MFLO read HI/LO directly, with no bypass from pend_*. The hazard unit stalls them in D while start|busy.
- md_op=0: no state change.

## Timing
- Reset values: HI=0, LO=0, pend_hi=0, pend_lo=0, cnt=0, busy=0. Consequently start=md_op∈{1..4}, md_out=0 unless MFHI/MFLO.
- Latency, with the start edge at cycle N:
  - busy is high in cycles N+1 … N+L (L = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO is visible from cycle N+L+1.
  - The next start is accepted at the edge ending cycle N+L+1 at the earliest.
- `start` is high in the cycle a mult/div occupies E. The hazard unit ORs it with busy, so a D-stage mult/div/mf/mt stalls without a one-cycle gap.
- Back-to-back commit and start: not possible, since start requires busy=0. An op held in E while busy is a protocol violation and is ignored, not queued.
- Reset asserted mid-operation clears everything asynchronously. The pending result is discarded and HI/LO read 0.
- MTHI/MTLO write takes effect at the same edge; the following cycle's MFHI/MFLO sees the new value.

## Test plan
- Reset, then MULT A=0xFFFFFFFF B=0x00000002 → busy high for exactly 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE. Same operands with MULTU → HI=0x00000001 LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7) B=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=2 → LO=3 HI=1.
- MTHI A=0x1234, then MTLO A=0x5678; DIV with B=0 → after 10 busy cycles HI=0x1234 LO=0x5678. MFHI md_out=0x1234, MFLO md_out=0x5678.
- During MULT busy, drive md_op=MTLO A=0xDEAD and md_op=DIVU → start=0, LO/HI and busy timing unaffected; committed result is the MULT's.
- Start DIV, assert reset asynchronously (not on a clock edge) at busy cycle 4 → busy, HI, LO drop to 0 immediately; no commit afterward.
- DIV A=0x80000000 B=0xFFFFFFFF → LO=0x80000000 HI=0x00000000. Then immediate MULT → accepted at the first edge with busy=0, start high that cycle.
